// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit of the multi-cycle MIPS datapath.
// Forms ea = base + offset, drives a req/ack data-memory port for
// LB/LBU/LH/LHU/LW/SB/SH/SW and returns extended load data or an error.
// Optional build macro MAU_TIMEOUT_EN: adds an ACCESS-state watchdog that
// ends a stalled access after TIMEOUT_CYCLES with bus_err=1.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] ea;

`ifdef MAU_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`else
  logic        unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

  // Half must be 2-byte aligned, word 4-byte aligned; size 11 is never legal.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate store data across lanes so the enabled lanes carry the right bytes.
  function automatic logic [31:0] lane_replicate(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return u ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return u ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign ea = base + offset;

  // Next-state and next-output logic for the IDLE/ACCESS/RESP controller.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    bus_err_d    = 1'b0;
    rdata_d      = rdata_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_be_d    = dmem_be_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    lane_d       = lane_q;
    size_d       = size_q;
    uns_d        = uns_q;
`ifdef MAU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lane_d = ea[1:0];
          size_d = size;
          uns_d  = uns;
          if (is_misaligned(size, ea[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            addr_err_d   = 1'b1;
            rdata_d      = 32'h0;
          end else begin
            state_d      = ACCESS;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store;
            dmem_be_d    = byte_enables(size, ea[1:0]);
            dmem_addr_d  = {ea[31:2], 2'b00};
            dmem_wdata_d = lane_replicate(size, wdata);
`ifdef MAU_TIMEOUT_EN
            cnt_d        = 32'h0;
`endif
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_be_d    = 4'b0000;
          rdata_d      = dmem_we_q ? 32'h0 : load_extend(dmem_rdata, lane_q, size_q, uns_q);
        end
`ifdef MAU_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          bus_err_d    = 1'b1;
          rdata_d      = 32'h0;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_be_d    = 4'b0000;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= 4'b0000;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      lane_q       <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
`ifdef MAU_TIMEOUT_EN
      cnt_q        <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      addr_err_q   <= addr_err_d;
      bus_err_q    <= bus_err_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_be_q    <= dmem_be_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
`ifdef MAU_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Ready gated by rst_n so nothing is taken while reset is held.
  assign req_ready  = (state_q == IDLE) && rst_n;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expected values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .size(size), .uns(uns), .base(base), .offset(offset),
    .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata), .addr_err(addr_err),
    .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; afterwards we are at accept+1.
  task automatic issue(input logic st, input logic [1:0] sz, input logic u,
                       input logic [31:0] b, input logic [31:0] off, input logic [31:0] wd);
    check("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; is_store = st; size = sz; uns = u;
    base = b; offset = off; wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd);
    check({tag, "_req"},   {31'b0, dmem_req}, 32'd1);
    check({tag, "_we"},    {31'b0, dmem_we}, {31'b0, we});
    check({tag, "_be"},    {28'b0, dmem_be}, {28'b0, be});
    check({tag, "_addr"},  dmem_addr, addr);
    if (we) check({tag, "_wdata"}, dmem_wdata, wd);
  endtask

  // Ack this cycle, then check the response pulse and return to idle.
  task automatic ack_and_resp(input string tag, input logic [31:0] rd, input logic [31:0] exp_rdata);
    dmem_ack = 1'b1; dmem_rdata = rd;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_rdata"},      rdata, exp_rdata);
    check({tag, "_addr_err"},   {31'b0, addr_err}, 32'd0);
    check({tag, "_bus_err"},    {31'b0, bus_err}, 32'd0);
    check({tag, "_req_drop"},   {31'b0, dmem_req}, 32'd0);
    tick();
    check({tag, "_resp_pulse_end"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_rdata_hold"},     rdata, exp_rdata);
    check({tag, "_ready_again"},    {31'b0, req_ready}, 32'd1);
  endtask

  task automatic misaligned(input string tag, input logic st, input logic [1:0] sz,
                            input logic [31:0] b, input logic [31:0] off);
    issue(st, sz, 1'b0, b, off, 32'hDEADBEEF);
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_addr_err"},   {31'b0, addr_err}, 32'd1);
    check({tag, "_rdata"},      rdata, 32'h0);
    check({tag, "_no_req"},     {31'b0, dmem_req}, 32'd0);
    tick();
    check({tag, "_addr_err_clr"}, {31'b0, addr_err}, 32'd0);
    check({tag, "_pulse_end"},    {31'b0, resp_valid}, 32'd0);
    check({tag, "_no_req2"},      {31'b0, dmem_req}, 32'd0);
  endtask

  initial begin
    logic [31:0] held_addr;
    bit got;

    rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; size = 2'b00; uns = 1'b0;
    base = 32'h0; offset = 32'h0; wdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #3;
    // reset state
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata",      rdata, 32'h0);
    check("rst_dmem_req",   {31'b0, dmem_req}, 32'd0);
    check("rst_dmem_be",    {28'b0, dmem_be}, 32'd0);
    check("rst_dmem_addr",  dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    check("rst_req_ready",  {31'b0, req_ready}, 32'd0);
    req_valid = 1'b1;
    tick();
    tick();
    check("rst_no_accept", {31'b0, dmem_req}, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_ready", {31'b0, req_ready}, 32'd1);

    // LB, ea=0xFFF wraps below base -> lane 3, sign-extend 0x80
    issue(1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0);
    check_port("lb", 1'b0, 4'b1000, 32'h0000_0FFC, 32'h0);
    check("lb_ready_busy", {31'b0, req_ready}, 32'd0);
    ack_and_resp("lb", 32'h80FF_7F00, 32'hFFFF_FF80);

    // LHU upper half
    issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h0);
    check_port("lhu", 1'b0, 4'b1100, 32'h0000_2000, 32'h0);
    ack_and_resp("lhu", 32'hBEEF_1234, 32'h0000_BEEF);

    // LH lower half, sign-extended
    issue(1'b0, 2'b01, 1'b0, 32'h0000_5000, 32'h0, 32'h0);
    check_port("lh", 1'b0, 4'b0011, 32'h0000_5000, 32'h0);
    ack_and_resp("lh", 32'h1234_8001, 32'hFFFF_8001);

    // LBU lane 1, zero-extended
    issue(1'b0, 2'b00, 1'b1, 32'h0000_5000, 32'h0000_0001, 32'h0);
    check_port("lbu", 1'b0, 4'b0010, 32'h0000_5000, 32'h0);
    ack_and_resp("lbu", 32'h0000_9A00, 32'h0000_009A);

    // LW aligned
    issue(1'b0, 2'b10, 1'b1, 32'h0000_5008, 32'h0, 32'h0);
    check_port("lw", 1'b0, 4'b1111, 32'h0000_5008, 32'h0);
    ack_and_resp("lw", 32'h8765_4321, 32'h8765_4321);

    // SB lane 1, store returns rdata=0
    issue(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0, 32'h0000_00A5);
    check_port("sb", 1'b1, 4'b0010, 32'h0000_3000, 32'hA5A5_A5A5);
    ack_and_resp("sb", 32'hFFFF_FFFF, 32'h0);

    // SH upper half
    issue(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0, 32'h1111_CAFE);
    check_port("sh", 1'b1, 4'b1100, 32'h0000_3000, 32'hCAFE_CAFE);
    ack_and_resp("sh", 32'h0, 32'h0);

    // SW with address wrap-around
    issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h1234_5678);
    check_port("sw", 1'b1, 4'b1111, 32'h0000_0004, 32'h1234_5678);
    ack_and_resp("sw", 32'h0, 32'h0);

    // Misaligned and illegal-size requests
    misaligned("lw_mis", 1'b0, 2'b10, 32'h0000_4002, 32'h0);
    misaligned("sh_mis", 1'b1, 2'b01, 32'h0000_6001, 32'h0);
    misaligned("size3",  1'b0, 2'b11, 32'h0000_7000, 32'h0);

    // Ack while idle is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 1'b0;
    check("idle_ack_no_resp", {31'b0, resp_valid}, 32'd0);
    check("idle_ack_no_req",  {31'b0, dmem_req}, 32'd0);
    tick();

    // Delayed ack: outputs hold for 5 cycles, then async reset mid-ACCESS
    issue(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0000_0010, 32'h0);
    held_addr = 32'h0000_8010;
    for (int i = 0; i < 5; i++) begin
      check("wait_req_held",  {31'b0, dmem_req}, 32'd1);
      check("wait_addr_held", dmem_addr, held_addr);
      check("wait_no_resp",   {31'b0, resp_valid}, 32'd0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req_drop",  {31'b0, dmem_req}, 32'd0);
    check("async_rst_addr_clr",  dmem_addr, 32'h0);
    check("async_rst_not_ready", {31'b0, req_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
      check("post_rst_no_req",  {31'b0, dmem_req}, 32'd0);
    end

`ifdef MAU_TIMEOUT_EN
    // No ack: watchdog ends the access with bus_err
    issue(1'b0, 2'b10, 1'b0, 32'h0000_9000, 32'h0, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (resp_valid) got = 1'b1;
      else tick();
    end
    check("to_resp_seen",  {31'b0, got}, 32'd1);
    check("to_bus_err",    {31'b0, bus_err}, 32'd1);
    check("to_addr_err",   {31'b0, addr_err}, 32'd0);
    check("to_rdata",      rdata, 32'h0);
    check("to_req_drop",   {31'b0, dmem_req}, 32'd0);
    tick();
    check("to_bus_err_clr", {31'b0, bus_err}, 32'd0);
    check("to_ready",       {31'b0, req_ready}, 32'd1);
`else
    got = 1'b0;
    check("no_to_bus_err", {31'b0, bus_err}, {31'b0, got});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit of the multi-cycle MIPS datapath; sits directly downstream of the 16-bit immediate sign-extender.
- Takes a base register value and the sign-extended offset, and forms the effective address.
- Drives a request/acknowledge data-memory port for LB/LBU/LH/LHU/LW/SB/SH/SW.
- Returns extended load data, or a misalignment error, to the writeback stage.

Parameters:
- TIMEOUT_CYCLES, 255, ACCESS-state cycles without dmem_ack before a bus error (used only with MAU_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  access request from control unit
- req_ready  output  1  unit idle, request accepted this cycle if req_valid=1
- is_store  input  1  1=store, 0=load
- size  input  2  00 byte, 01 half, 10 word, 11 illegal
- uns  input  1  1=zero-extend load (LBU/LHU), ignored for stores and LW
- base  input  32  rs register value
- offset  input  32  sign-extended immediate
- wdata  input  32  rt value for stores
- resp_valid  output  1  one-cycle completion pulse
- rdata  output  32  extended load data, 0 for stores/errors
- addr_err  output  1  misaligned/illegal-size flag, valid with resp_valid
- bus_err  output  1  timeout flag, valid with resp_valid
- dmem_req  output  1  memory request, held until ack
- dmem_we  output  1  write enable
- dmem_be  output  4  byte enables, bit i = byte lane i
- dmem_addr  output  32  word-aligned address
- dmem_wdata  output  32  lane-replicated store data
- dmem_ack  input  1  memory completion, single-cycle
- dmem_rdata  input  32  read word, valid with dmem_ack

Behaviour:
- Reset (async, rst_n=0): state IDLE. resp_valid, rdata, addr_err, bus_err, dmem_req, dmem_we, dmem_be, dmem_addr and dmem_wdata all 0. No request is accepted while rst_n=0.
- FSM states: IDLE, ACCESS, RESP. req_ready=1 only in IDLE.
- Effective address: ea = base + offset, mod 2^32; wrap-around is legal and not flagged.
- IDLE, on req_valid:
  - Compute ea, register it, and register the op fields.
  - Misaligned when size=01 and ea[0]=1, size=10 and ea[1:0]!=0, or size=11. A misaligned request goes to RESP with addr_err=1, and dmem_req is never asserted.
  - Otherwise go to ACCESS; dmem_req=1 from the next cycle.
- ACCESS:
  - dmem_addr={ea[31:2],2'b00}. dmem_we=is_store.
  - dmem_be: byte = 4'b0001<<ea[1:0]; half = ea[1] ? 1100 : 0011; word = 1111.
  - dmem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
  - All dmem outputs are stable until the dmem_ack cycle.
  - On dmem_ack: drop dmem_req next cycle, capture the load result, go to RESP.
- Load extraction (little-endian):
  - Byte lane is ea[1:0]; half lane is ea[1].
  - Sign-extend unless uns=1; zero-extend when uns=1.
  - LW passes dmem_rdata unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle; rdata, addr_err and bus_err are valid this cycle.
  - Next state is IDLE. There is no backpressure.
  - resp_valid, addr_err and bus_err return to 0 after the pulse; rdata holds its last value.
- Latency:
  - Accept at cycle N; dmem_req is high at N+1.
  - Ack at cycle M (M >= N+1) gives resp_valid at M+1.
  - Misaligned request: resp_valid at N+1.
- dmem_ack outside ACCESS is ignored.
- Back-to-back requests: a new request is accepted only in IDLE, i.e. at RESP+1 at the earliest.
- Reset mid-ACCESS: dmem_req drops immediately (asynchronous) and no response is produced.

Optional Feature:
- Macro MAU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without dmem_ack.
  - When the count reaches TIMEOUT_CYCLES: drop dmem_req and go to RESP with bus_err=1, rdata=0.
  - An ack arriving in the same cycle as the timeout wins; bus_err=0.
- Undefined: ACCESS waits indefinitely, bus_err is tied to 0, and no counter is present.

Test Plan:
- LB with base=0x1000, offset=0xFFFFFFFF, dmem_rdata=0x80FF7F00, ack at N+1 -> dmem_addr=0x00000FFC, be=1000, rdata=0xFFFFFF80 at N+2.
- LHU with base=0x2002, offset=0, dmem_rdata=0xBEEF1234 -> be=1100, rdata=0x0000BEEF.
- SB with base=0x3001, wdata=0x000000A5 -> dmem_we=1, be=0010, dmem_wdata=0xA5A5A5A5; resp_valid one cycle after ack, rdata=0.
- LW with base=0x4002 -> addr_err=1 at N+1, dmem_req never high.
- SW with base=0xFFFFFFFC, offset=8 -> dmem_addr=0x00000004 (wrap), be=1111.
- Ack delayed 5 cycles, then rst_n pulsed mid-ACCESS -> dmem_req=0 immediately, no resp_valid, req_ready=1 after release. With MAU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> bus_err=1 resp.
